// File: rtl/branch_predictor_gshare_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : bp_pkg
//  Description : Shared types and helpers for the fetch-stage branch
//                predictor: branch-class and RAS-operation encodings,
//                saturating counter init/increment/decrement, and
//                instruction classification.
//  Revision    : 1.0  initial release
// ============================================================================
package bp_pkg;

    // Widest supported counter; helpers work at this width and callers
    // truncate back to their own counter width.
    localparam int c_ctr_max_w = 3;

    // Link register index used for call/return detection.
    localparam logic [4:0] c_reg_ra = 5'd1;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_COND = 2'd1,
        BR_JAL  = 2'd2,
        BR_JALR = 2'd3
    } br_class_e;

    typedef enum logic [1:0] {
        RAS_NONE = 2'd0,
        RAS_PUSH = 2'd1,
        RAS_POP  = 2'd2,
        RAS_SWAP = 2'd3
    } ras_op_e;

    // Weakly-not-taken: MSB clear, all lower bits set.
    function automatic logic [c_ctr_max_w-1:0] ctr_init(input int unsigned w);
        return c_ctr_max_w'((1 << (w - 1)) - 1);
    endfunction

    function automatic logic [c_ctr_max_w-1:0] ctr_max(input int unsigned w);
        return c_ctr_max_w'((1 << w) - 1);
    endfunction

    function automatic logic [c_ctr_max_w-1:0] ctr_inc(input logic [c_ctr_max_w-1:0] c,
                                                        input int unsigned w);
        return (c >= ctr_max(w)) ? c : c + 1'b1;
    endfunction

    function automatic logic [c_ctr_max_w-1:0] ctr_dec(input logic [c_ctr_max_w-1:0] c);
        return (c == '0) ? c : c - 1'b1;
    endfunction

    // {branch,predict}: 0x -> none, 11 -> conditional, 10 -> jump (jal/jalr).
    function automatic br_class_e classify(input logic is_branch,
                                           input logic is_cond,
                                           input logic is_jal);
        if (!is_branch) return BR_NONE;
        if (is_cond)    return BR_COND;
        return is_jal ? BR_JAL : BR_JALR;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predictor_gshare_ras.sv
`default_nettype none
// ============================================================================
//  Module      : bp_ras
//  Description : Circular return-address stack. The pointer always names the
//                top entry; a push on a full stack silently overwrites the
//                oldest entry while the occupancy count saturates at depth.
//  Ports       : clk, rst   clock / synchronous active-high reset
//                i_op       RAS_NONE / RAS_PUSH / RAS_POP / RAS_SWAP
//                i_data     return address written by push or swap
//                o_top      entry at the current pointer
//                o_empty    occupancy count is zero
//  Revision    : 1.0  initial release
// ============================================================================
module bp_ras
    import bp_pkg::*;
#(
    parameter int RAS_DEPTH = 16,
    parameter int PC_W      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  ras_op_e         i_op,
    input  logic [PC_W-1:0] i_data,
    output logic [PC_W-1:0] o_top,
    output logic            o_empty
);

    localparam int c_ptr_w = $clog2(RAS_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [PC_W-1:0]    mem_q [RAS_DEPTH];
    logic [c_ptr_w-1:0] ptr_q, ptr_d;
    logic [c_cnt_w-1:0] count_q, count_d;
    logic               w_we;
    logic [c_ptr_w-1:0] w_waddr;

    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        w_we    = 1'b0;
        w_waddr = ptr_q;
        case (i_op)
            RAS_PUSH: begin
                // Pointer wraps naturally because depth is a power of two.
                ptr_d   = ptr_q + 1'b1;
                w_we    = 1'b1;
                w_waddr = ptr_q + 1'b1;
                if (count_q != c_cnt_w'(RAS_DEPTH)) begin
                    count_d = count_q + 1'b1;
                end
            end
            RAS_POP: begin
                if (count_q != '0) begin
                    ptr_d   = ptr_q - 1'b1;
                    count_d = count_q - 1'b1;
                end
            end
            RAS_SWAP: begin
                w_we = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset: entries are only ever read while count > 0.
    always_ff @(posedge clk) begin
        if (!rst && w_we) begin
            mem_q[w_waddr] <= i_data;
        end
    end

    assign o_top   = mem_q[ptr_q];
    assign o_empty = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/branch_predictor_gshare.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor_gshare
//  Description : Fetch-stage next-PC predictor. Saturating-counter PHT
//                (gshare or bimodal indexing), return-address stack,
//                exception redirect and sepc capture. Prediction is purely
//                combinational; all state updates on posedge clk.
//  Macro       : BP_GSHARE_EN  defined   -> PHT index = pc bits XOR GHR
//                              undefined -> bimodal, GHR held at zero
//  Ports       : pc/imm/branch/predict/ujtype/rs1/rd/rs1_data  IF/ID inputs
//                excp                                          exception now
//                upd_*                                         EX resolution
//                target_pc, predict_result                     prediction
//                pred_ghr                                      GHR snapshot
//                predict_fail                                  flush request
//                sepc                                          exception PC+4
//  Revision    : 1.0  initial release
// ============================================================================
module branch_predictor_gshare
    import bp_pkg::*;
#(
    parameter int              PC_W      = 32,
    parameter int              PHT_IDX_W = 10,
    parameter int              GHR_W     = 8,
    parameter int              CTR_W     = 2,
    parameter int              RAS_DEPTH = 16,
    parameter logic [PC_W-1:0] EXCP_ADDR = 32'h1C09_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PC_W-1:0]  pc,
    input  logic [PC_W-1:0]  imm,
    input  logic             branch,
    input  logic             predict,
    input  logic             ujtype,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rd,
    input  logic [PC_W-1:0]  rs1_data,
    input  logic             excp,
    input  logic             upd_valid,
    input  logic [PC_W-1:0]  upd_pc,
    input  logic [PC_W-1:0]  upd_target,
    input  logic             upd_taken,
    input  logic             upd_pred,
    input  logic             upd_cond,
    input  logic [GHR_W-1:0] upd_ghr,
    output logic [PC_W-1:0]  target_pc,
    output logic             predict_result,
    output logic [GHR_W-1:0] pred_ghr,
    output logic             predict_fail,
    output logic [PC_W-1:0]  sepc
);

    localparam int               c_pht_depth = 1 << PHT_IDX_W;
    localparam logic [CTR_W-1:0] c_ctr_init  = CTR_W'(ctr_init(CTR_W));

    logic [CTR_W-1:0]     pht_q [c_pht_depth];
    logic [GHR_W-1:0]     ghr_q, ghr_d;
    logic                 started_q, started_d;
    logic [PC_W-1:0]      sepc_q, sepc_d;

    br_class_e            w_class;
    ras_op_e              w_ras_op;
    logic                 w_active;
    logic                 w_fail;
    logic [PC_W-1:0]      w_pc_plus4;
    logic [PC_W-1:0]      w_pc_imm;
    logic [PC_W-1:0]      w_jalr_tgt;
    logic [PC_W-1:0]      w_ras_top;
    logic                 w_ras_empty;
    logic                 w_ras_hit;
    logic [PHT_IDX_W-1:0] w_pred_idx;
    logic [PHT_IDX_W-1:0] w_upd_idx;
    logic [CTR_W-1:0]     w_ctr_rd;
    logic                 w_cond_taken;
    logic [CTR_W-1:0]     w_ctr_old;
    logic [c_ctr_max_w-1:0] w_ctr_wide;
    logic [CTR_W-1:0]     w_ctr_new;
    logic                 w_unused_bits;

    // ------------------------------------------------------------------
    // Decode and shared arithmetic
    // ------------------------------------------------------------------
    assign w_class    = classify(branch, predict, ujtype);
    assign w_active   = started_q & ~rst;
    assign w_fail     = upd_valid & (upd_pred != upd_taken);
    assign w_pc_plus4 = pc + PC_W'(4);
    assign w_pc_imm   = pc + imm;
    assign w_jalr_tgt = rs1_data + imm;
    assign w_ras_hit  = (rs1 == c_reg_ra) & ~w_ras_empty;

    // ------------------------------------------------------------------
    // PHT indexing
    // ------------------------------------------------------------------
`ifdef BP_GSHARE_EN
    assign w_pred_idx    = pc[PHT_IDX_W+1:2]     ^ PHT_IDX_W'(ghr_q);
    assign w_upd_idx     = upd_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(upd_ghr);
    assign w_unused_bits = ^{upd_pc, w_ctr_wide};
`else
    assign w_pred_idx    = pc[PHT_IDX_W+1:2];
    assign w_upd_idx     = upd_pc[PHT_IDX_W+1:2];
    assign w_unused_bits = ^{upd_pc, upd_ghr, w_ctr_wide};
`endif

    assign w_ctr_rd     = pht_q[w_pred_idx];
    assign w_cond_taken = w_ctr_rd[CTR_W-1];

    // ------------------------------------------------------------------
    // Next-fetch prediction
    // ------------------------------------------------------------------
    always_comb begin
        target_pc      = '0;
        predict_result = 1'b0;
        if (w_active) begin
            if (excp) begin
                target_pc = EXCP_ADDR;
            end else if (w_fail) begin
                target_pc      = upd_target;
                predict_result = upd_taken;
            end else begin
                case (w_class)
                    BR_JAL: begin
                        target_pc      = w_pc_imm;
                        predict_result = 1'b1;
                    end
                    BR_JALR: begin
                        target_pc      = w_ras_hit ? w_ras_top : w_jalr_tgt;
                        predict_result = 1'b1;
                    end
                    BR_COND: begin
                        target_pc      = w_cond_taken ? w_pc_imm : w_pc_plus4;
                        predict_result = w_cond_taken;
                    end
                    default: begin
                        target_pc = w_pc_plus4;
                    end
                endcase
            end
        end
    end

    assign predict_fail = w_fail;
    assign pred_ghr     = ghr_q;
    assign sepc         = sepc_q;

    // ------------------------------------------------------------------
    // Return-address stack
    // ------------------------------------------------------------------
    // Calls push, returns pop; a jalr that both reads and writes ra
    // replaces the top in place. Flushes and exceptions squash the op.
    always_comb begin
        w_ras_op = RAS_NONE;
        if (w_active && !excp && !w_fail) begin
            if (w_class == BR_JAL) begin
                if (rd == c_reg_ra) w_ras_op = RAS_PUSH;
            end else if (w_class == BR_JALR) begin
                if (rs1 == c_reg_ra && rd == c_reg_ra) w_ras_op = RAS_SWAP;
                else if (rd == c_reg_ra)               w_ras_op = RAS_PUSH;
                else if (rs1 == c_reg_ra)              w_ras_op = RAS_POP;
            end
        end
    end

    bp_ras #(
        .RAS_DEPTH (RAS_DEPTH),
        .PC_W      (PC_W)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .i_op    (w_ras_op),
        .i_data  (w_pc_plus4),
        .o_top   (w_ras_top),
        .o_empty (w_ras_empty)
    );

    // ------------------------------------------------------------------
    // Global history
    // ------------------------------------------------------------------
`ifdef BP_GSHARE_EN
    logic [GHR_W-1:0] w_upd_shift;
    logic [GHR_W-1:0] w_pred_shift;

    generate
        if (GHR_W == 1) begin : g_ghr_one
            assign w_upd_shift  = upd_taken;
            assign w_pred_shift = w_cond_taken;
        end else begin : g_ghr_wide
            assign w_upd_shift  = {upd_ghr[GHR_W-2:0], upd_taken};
            assign w_pred_shift = {ghr_q[GHR_W-2:0], w_cond_taken};
        end
    endgenerate

    // A flush rebuilds history from the snapshot that travelled with the
    // resolved branch; otherwise speculative history tracks predictions.
    always_comb begin
        ghr_d = ghr_q;
        if (w_fail && upd_cond) begin
            ghr_d = w_upd_shift;
        end else if (w_fail) begin
            ghr_d = upd_ghr;
        end else if (w_active && !excp && w_class == BR_COND) begin
            ghr_d = w_pred_shift;
        end
    end
`else
    always_comb begin
        ghr_d = '0;
    end
`endif

    // ------------------------------------------------------------------
    // PHT update
    // ------------------------------------------------------------------
    always_comb begin
        w_ctr_old  = pht_q[w_upd_idx];
        w_ctr_wide = upd_taken ? ctr_inc(c_ctr_max_w'(w_ctr_old), CTR_W)
                               : ctr_dec(c_ctr_max_w'(w_ctr_old));
        w_ctr_new  = w_ctr_wide[CTR_W-1:0];
    end

    // Prediction reads pht_q combinationally, so a same-index write in
    // this cycle is only visible from the next cycle on.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_pht_depth; i++) begin
                pht_q[i] <= c_ctr_init;
            end
        end else if (upd_valid && upd_cond) begin
            pht_q[w_upd_idx] <= w_ctr_new;
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_comb begin
        started_d = 1'b1;
        sepc_d    = excp ? w_pc_plus4 : sepc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            started_q <= 1'b0;
            ghr_q     <= '0;
            sepc_q    <= '0;
        end else begin
            started_q <= started_d;
            ghr_q     <= ghr_d;
            sepc_q    <= sepc_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_gshare.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predictor_gshare
//  Description : Directed self-checking bench for branch_predictor_gshare.
//                Expected predictions are queued as stimulus is applied and
//                popped when the combinational outputs are sampled.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_branch_predictor_gshare;

    localparam int          PC_W      = 32;
    localparam int          GHR_W     = 8;
    localparam int          RAS_DEPTH = 4;
    localparam logic [31:0] EXCP_ADDR = 32'h1C09_0000;

    logic             clk = 1'b0;
    logic             rst;
    logic [PC_W-1:0]  pc, imm, rs1_data, upd_pc, upd_target;
    logic             branch, predict, ujtype, excp;
    logic [4:0]       rs1, rd;
    logic             upd_valid, upd_taken, upd_pred, upd_cond;
    logic [GHR_W-1:0] upd_ghr;
    logic [PC_W-1:0]  target_pc, sepc;
    logic             predict_result, predict_fail;
    logic [GHR_W-1:0] pred_ghr;

    always #5 clk = ~clk;

    branch_predictor_gshare #(
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .imm            (imm),
        .branch         (branch),
        .predict        (predict),
        .ujtype         (ujtype),
        .rs1            (rs1),
        .rd             (rd),
        .rs1_data       (rs1_data),
        .excp           (excp),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_target     (upd_target),
        .upd_taken      (upd_taken),
        .upd_pred       (upd_pred),
        .upd_cond       (upd_cond),
        .upd_ghr        (upd_ghr),
        .target_pc      (target_pc),
        .predict_result (predict_result),
        .pred_ghr       (pred_ghr),
        .predict_fail   (predict_fail),
        .sepc           (sepc)
    );

    typedef struct {
        string       tag;
        logic [31:0] tgt;
        logic        res;
        logic        chk_res;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pc = '0; imm = '0; rs1_data = '0;
        branch = 1'b0; predict = 1'b0; ujtype = 1'b0; excp = 1'b0;
        rs1 = '0; rd = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_target = '0;
        upd_taken = 1'b0; upd_pred = 1'b0; upd_cond = 1'b0; upd_ghr = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic set_br(input logic [31:0] p, input logic b, input logic pr,
                          input logic uj, input logic [4:0] s1, input logic [4:0] d,
                          input logic [31:0] s1d, input logic [31:0] im);
        pc = p; branch = b; predict = pr; ujtype = uj;
        rs1 = s1; rd = d; rs1_data = s1d; imm = im;
    endtask

    task automatic set_upd(input logic v, input logic [31:0] upc, input logic [31:0] tgt,
                           input logic tk, input logic pd, input logic cnd,
                           input logic [7:0] gh);
        upd_valid = v; upd_pc = upc; upd_target = tgt;
        upd_taken = tk; upd_pred = pd; upd_cond = cnd; upd_ghr = gh;
    endtask

    task automatic sb_push(input string tag, input logic [31:0] tgt,
                           input logic res, input logic chk_res);
        exp_t e;
        e.tag = tag; e.tgt = tgt; e.res = res; e.chk_res = chk_res;
        sb_q.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        #2;
        if (sb_q.size() == 0) begin
            n_total++;
            n_fail++;
            $error("FAIL scoreboard_underflow: observed target 0x%08h expected a queued entry", target_pc);
        end else begin
            e = sb_q.pop_front();
            chk({e.tag, "_tgt"}, target_pc, e.tgt);
            if (e.chk_res) chk({e.tag, "_res"}, {31'b0, predict_result}, {31'b0, e.res});
        end
    endtask

    initial begin
        logic [31:0] ret_exp [6];
        logic [7:0]  exp_ghr_a, exp_ghr_b;

`ifdef BP_GSHARE_EN
        exp_ghr_a = 8'b0100_0001;
        exp_ghr_b = 8'h5A;
`else
        exp_ghr_a = 8'h00;
        exp_ghr_b = 8'h00;
`endif

        // ---------------- reset state and start-up gating ----------------
        idle();
        rst = 1'b1;
        set_br(32'h100, 1, 0, 1, 5'd0, 5'd0, 32'h0, 32'h40);
        sb_push("rst_hold", 32'h0, 1'b0, 1'b1);
        tick();
        sb_check();
        chk("rst_pred_ghr", 32'(pred_ghr), 32'h0);
        chk("rst_sepc", sepc, 32'h0);
        rst = 1'b0;
        sb_push("not_started", 32'h0, 1'b0, 1'b1);
        sb_check();
        tick();
        sb_push("jal_first", 32'h140, 1'b1, 1'b1);
        sb_check();
        tick();

        // ---------------- conditional training at pc=0x100 ----------------
        do_reset();
        set_br(32'h100, 1, 1, 0, 5'd0, 5'd0, 32'h0, 32'h40);
        sb_push("cond_init", 32'h104, 1'b0, 1'b1);
        sb_check();
        tick();
        set_upd(1, 32'h100, 32'h140, 1, 1, 1, 8'h00);
        sb_push("cond_same_cycle_rw", 32'h104, 1'b0, 1'b1);
        sb_check();
        chk("no_flush", {31'b0, predict_fail}, 32'h0);
        tick();
        branch = 1'b0;
        tick();
        set_upd(0, 32'h0, 32'h0, 0, 0, 0, 8'h00);
        branch = 1'b1;
        sb_push("cond_trained", 32'h140, 1'b1, 1'b1);
        sb_check();
        tick();

        // ---------------- counter saturation at pc=0x200 ----------------
        do_reset();
        set_upd(1, 32'h200, 32'h204, 0, 0, 1, 8'h00);
        repeat (6) tick();
        set_upd(1, 32'h200, 32'h240, 1, 1, 1, 8'h00);
        tick();
        idle();
        set_br(32'h200, 1, 1, 0, 5'd0, 5'd0, 32'h0, 32'h40);
        sb_push("sat_one_taken", 32'h204, 1'b0, 1'b1);
        sb_check();
        tick();
        idle();
        set_upd(1, 32'h200, 32'h240, 1, 1, 1, 8'h00);
        tick();
        idle();
        set_br(32'h200, 1, 1, 0, 5'd0, 5'd0, 32'h0, 32'h40);
        sb_push("sat_two_taken", 32'h240, 1'b1, 1'b1);
        sb_check();
        tick();

        // ---------------- mispredict flush and GHR repair ----------------
        do_reset();
        set_br(32'h50, 0, 0, 0, 5'd0, 5'd0, 32'h0, 32'h0);
        set_upd(1, 32'h300, 32'h200, 1, 0, 1, 8'b1010_0000);
        sb_push("mispredict", 32'h200, 1'b1, 1'b1);
        sb_check();
        chk("mispredict_flag", {31'b0, predict_fail}, 32'h1);
        tick();
        idle();
        #2;
        chk("ghr_after_cond_fail", 32'(pred_ghr), 32'(exp_ghr_a));
        set_upd(1, 32'h300, 32'h500, 0, 1, 0, 8'h5A);
        sb_push("mispredict_uncond", 32'h500, 1'b0, 1'b1);
        sb_check();
        chk("mispredict_uncond_flag", {31'b0, predict_fail}, 32'h1);
        tick();
        idle();
        #2;
        chk("ghr_after_uncond_fail", 32'(pred_ghr), 32'(exp_ghr_b));

        // ---------------- exception redirect and sepc ----------------
        do_reset();
        set_br(32'h300, 1, 0, 0, 5'd5, 5'd1, 32'h800, 32'h4);
        excp = 1'b1;
        sb_push("excp_vec", EXCP_ADDR, 1'b0, 1'b0);
        sb_check();
        tick();
        idle();
        #2;
        chk("sepc_capture", sepc, 32'h304);
        set_br(32'h400, 1, 0, 0, 5'd1, 5'd0, 32'h1000, 32'h8);
        sb_push("ret_after_excp", 32'h1008, 1'b1, 1'b1);
        sb_check();
        tick();
        idle();
        #2;
        chk("sepc_hold", sepc, 32'h304);
        set_br(32'h600, 0, 0, 0, 5'd0, 5'd0, 32'h0, 32'h0);
        set_upd(1, 32'h300, 32'h999, 1, 0, 1, 8'h00);
        excp = 1'b1;
        sb_push("excp_over_flush", EXCP_ADDR, 1'b0, 1'b0);
        sb_check();
        tick();
        idle();
        #2;
        chk("sepc_second", sepc, 32'h604);

        // ---------------- RAS overflow / underflow (depth 4) ----------------
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            set_br(32'(i * 16), 1, 0, 1, 5'd0, 5'd1, 32'h0, 32'h100);
            sb_push($sformatf("call%0d", i), 32'(i * 16 + 256), 1'b1, 1'b1);
            sb_check();
            tick();
        end
        ret_exp = '{32'h54, 32'h44, 32'h34, 32'h24, 32'h7010, 32'h7010};
        for (int i = 0; i < 6; i++) begin
            set_br(32'h900, 1, 0, 0, 5'd1, 5'd0, 32'h7000, 32'h10);
            sb_push($sformatf("ret%0d", i), ret_exp[i], 1'b1, 1'b1);
            sb_check();
            tick();
        end
        set_br(32'h60, 1, 0, 1, 5'd0, 5'd1, 32'h0, 32'h100);
        sb_push("call_after_empty", 32'h160, 1'b1, 1'b1);
        sb_check();
        tick();
        set_br(32'hA0, 1, 0, 0, 5'd1, 5'd1, 32'h7000, 32'h10);
        sb_push("swap", 32'h64, 1'b1, 1'b1);
        sb_check();
        tick();
        set_br(32'h900, 1, 0, 0, 5'd1, 5'd0, 32'h7000, 32'h10);
        sb_push("ret_after_swap", 32'hA4, 1'b1, 1'b1);
        sb_check();
        tick();
        sb_push("ret_empty_again", 32'h7010, 1'b1, 1'b1);
        sb_check();
        tick();

`ifndef BP_GSHARE_EN
        // ---------------- bimodal aliasing ----------------
        do_reset();
        set_upd(1, 32'h1100, 32'h1140, 1, 1, 1, 8'hFF);
        tick();
        set_upd(1, 32'h1100, 32'h1140, 1, 1, 1, 8'h3C);
        tick();
        idle();
        set_br(32'h100, 1, 1, 0, 5'd0, 5'd0, 32'h0, 32'h40);
        sb_push("alias", 32'h140, 1'b1, 1'b1);
        sb_check();
        chk("alias_pred_ghr", 32'(pred_ghr), 32'h0);
        tick();
        idle();
        #2;
        chk("alias_pred_ghr_after", 32'(pred_ghr), 32'h0);
`endif

        chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_predictor_gshare.md
Name: branch_predictor_gshare

Overview:
- Parametrised next-generation fetch-stage predictor: N-bit saturating-counter PHT indexed by PC XOR global history (gshare), circular return-address stack (RAS) with occupancy tracking, exception redirect and sepc capture.
- Sits between IF (pc), ID (imm, decode class) and EX (resolution/update). Drives next-fetch PC and flush request.

Parameters:
- PC_W, 32, PC/data width
- PHT_IDX_W, 10, PHT index bits; PHT depth = 2**PHT_IDX_W
- GHR_W, 8, global history length; legal range 1..PHT_IDX_W
- CTR_W, 2, counter width; legal range 2..3
- RAS_DEPTH, 16, RAS entries; power of 2, >= 2
- EXCP_ADDR, 32'h1C090000, exception vector

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous active-high reset
- pc  in  PC_W  IF fetch PC
- imm  in  PC_W  ID sign-extended immediate
- branch  in  1  control-flow instruction
- predict  in  1  conditional branch; {branch,predict}=10 is an unconditional jump
- ujtype  in  1  jal (1) vs jalr (0)
- rs1, rd  in  5  register indices
- rs1_data  in  PC_W  jalr base value
- excp  in  1  exception taken this cycle
- upd_valid  in  1  EX resolution valid
- upd_pc  in  PC_W  resolved branch PC
- upd_target  in  PC_W  correct next PC
- upd_taken  in  1  actual outcome
- upd_pred  in  1  outcome predicted earlier
- upd_cond  in  1  resolved instruction is a conditional branch
- upd_ghr  in  GHR_W  GHR snapshot travelling with that branch
- target_pc  out  PC_W  next fetch PC
- predict_result  out  1  predicted taken
- pred_ghr  out  GHR_W  GHR snapshot at prediction, carried to EX
- predict_fail  out  1  flush request
- sepc  out  PC_W  exception return PC

Behaviour:
- Reset: all PHT counters = weakly-not-taken (2**(CTR_W-1)-1); GHR=0; RAS ptr=0, count=0; sepc=0; started=0. While rst or !started: target_pc=0, predict_result=0. started sets on the first posedge after rst deasserts.
- predict_fail = upd_valid & (upd_pred != upd_taken).
- Prediction is combinational, zero latency. Priority: excp -> target_pc=EXCP_ADDR; else predict_fail -> target_pc=upd_target, predict_result=upd_taken; else by class:
  - jal: target_pc=pc+imm; predict_result=1.
  - jalr with rs1==1 and count>0: target_pc = RAS[ptr]; otherwise target_pc = rs1_data+imm. predict_result=1.
  - cond: idx = pc[PHT_IDX_W+1:2] XOR zero-extended GHR; taken when counter MSB=1; target_pc = taken ? pc+imm : pc+4.
  - none: target_pc=pc+4.
- All adds truncate to PC_W.
- pred_ghr = GHR, driven every cycle.
- GHR update, one per posedge. Priority order:
  - predict_fail & upd_cond: GHR <= {upd_ghr[GHR_W-2:0], upd_taken}.
  - predict_fail & !upd_cond: GHR <= upd_ghr.
  - Otherwise, on a new cond prediction: GHR <= {GHR[GHR_W-2:0], predict_result}.
  - GHR_W=1 degenerates to the outcome bit.
- PHT update when upd_valid & upd_cond, at idx = upd_pc[..] XOR upd_ghr. Counter saturates at 0 and 2**CTR_W-1. Same-cycle read/write of the same index: the read sees the old value.
- RAS, jalr/jal only, suppressed on predict_fail or excp:
  - Push (rd==1): ptr<=ptr+1 mod RAS_DEPTH; RAS[ptr+1]<=pc+4; count<=min(count+1, RAS_DEPTH). When full, this overwrites the oldest entry.
  - Pop (jalr, rs1==1, rd!=1): ptr<=ptr-1; count<=count-1. At count 0 there is no change.
  - Push and pop together (rs1==1, rd==1): RAS[ptr]<=pc+4; ptr and count unchanged.
- sepc <= pc+4 on the posedge where excp=1; otherwise holds.
- rst mid-operation overrides all updates in that cycle.

Optional Feature:
- Macro BP_GSHARE_EN.
- Defined: gshare indexing and GHR as above.
- Undefined: bimodal. idx = pc bits only; GHR held at 0; pred_ghr=0; upd_ghr is ignored.

Decomposition:
- Package bp_pkg: counter-init and saturating inc/dec functions, branch-class enum {BR_NONE, BR_COND, BR_JAL, BR_JALR}, RAS op enum {RAS_NONE, RAS_PUSH, RAS_POP, RAS_SWAP}.
- One sub-module, bp_ras: circular stack with ptr/count, parametrised by RAS_DEPTH and PC_W.

Test Plan:
- Reset, then cond branch at pc=0x100, imm=0x40, upd_taken=1 resolved twice -> third prediction predict_result=1, target_pc=0x140.
- Exception while a jalr push is in flight -> target_pc=EXCP_ADDR, sepc=pc+4, RAS count unchanged.
- RAS_DEPTH=4: five calls at pc=0x10,0x20,0x30,0x40,0x50, then five rets -> targets 0x54,0x44,0x34,0x24, then rs1_data+imm for the fifth.
- Mispredict: upd_pred=0, upd_taken=1, upd_target=0x200, upd_ghr=8'b1010_0000 -> predict_fail=1, target_pc=0x200; next cycle pred_ghr=8'b0100_0001.
- Counter saturation: six not-taken resolutions on one index -> counter=0; one taken -> counter=1, prediction still not-taken.
- Compile without BP_GSHARE_EN: two PCs with identical pc[11:2] alias to one counter regardless of history; pred_ghr stays 0.
